uart_cmd_decoder: RTL and testbench

Frames the byte stream produced by the UART receiver into 4-byte game command packets and drives the Pong game logic. It sits directly downstream of the UART receiver and consumes its one-cycle byte-valid strobe and data byte. It outputs:
- held paddle-motion levels for both players;
- one-cycle game-control pulses;
- a saturating error counter for debug display.

---
 rtl/uart_cmd_decoder_pkg.sv | 42 ++++
 rtl/uart_cmd_decoder_if.sv | 8 +
 rtl/uart_cmd_decoder_hold_timer.sv | 54 +++++
 rtl/uart_cmd_decoder.sv | 181 ++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_decoder_pkg.sv
// Shared constants for the Pong command decoder: packet bytes, command/argument codes and FSM encoding.
// Also provides small decode helpers that the top module uses.
package uart_cmd_decoder_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;

  localparam logic [7:0] CMD_P1_MOVE   = 8'h01;
  localparam logic [7:0] CMD_P2_MOVE   = 8'h02;
  localparam logic [7:0] CMD_START     = 8'h10;
  localparam logic [7:0] CMD_PAUSE     = 8'h11;
  localparam logic [7:0] CMD_SCORE_CLR = 8'h12;

  localparam logic [7:0] ARG_STOP      = 8'h00;
  localparam logic [7:0] ARG_UP        = 8'h01;
  localparam logic [7:0] ARG_DOWN      = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_CMD = 3'd1,
    ST_GET_ARG = 3'd2,
    ST_GET_SUM = 3'd3,
    ST_EXEC    = 3'd4
  } state_e;

  function automatic logic [7:0] pkt_sum(input logic [7:0] cmd, input logic [7:0] arg);
    return cmd + arg;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? 8'hFF : value + 8'd1;
  endfunction

  // Returns {up, dn}; anything other than up/down reads as stop.
  function automatic logic [1:0] move_levels(input logic [7:0] arg);
    case (arg)
      ARG_UP:   return 2'b10;
      ARG_DOWN: return 2'b01;
      default:  return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Byte stream handshake between the UART receiver (master) and the command decoder (slave).
interface uart_cmd_decoder_if;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;

  modport master (output i_RX_DV, output i_RX_Byte);
  modport slave  (input  i_RX_DV, input  i_RX_Byte);
endinterface

// File: rtl/uart_cmd_decoder_hold_timer.sv
// paddle_hold_timer: counts from the last reload and emits a one-cycle registered expire pulse
// timed so that the paddle levels drop HOLD_CLKS-1 clocks after they were loaded.
module paddle_hold_timer #(
  parameter int HOLD_CLKS = 2500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic reload_i,
  output logic expire_o
);

  localparam int              CNT_W     = $clog2(HOLD_CLKS);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CLKS - 2);
  localparam logic [CNT_W-1:0] HOLD_PRE  = CNT_W'(HOLD_CLKS - 3);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             expire_q, expire_d;

  // Expire is pre-decoded one count early so the pulse leaves a flop.
  always_comb begin
    cnt_d    = '0;
    run_d    = 1'b0;
    expire_d = 1'b0;
    if (reload_i) begin
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == HOLD_LAST) begin
        run_d = 1'b0;
      end else begin
        run_d    = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        expire_d = (cnt_q == HOLD_PRE);
      end
    end else begin
      run_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      run_q    <= 1'b0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Frames UART bytes into SYNC/CMD/ARG/SUM packets and drives paddle levels, control pulses
// and a saturating reject counter for the Pong game logic.
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int TIMEOUT_CLKS = 10 * CLKS_PER_BIT * 4,
  parameter int HOLD_CLKS    = 2500000
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  uart_cmd_decoder_if.slave    rx,
  output logic                 o_P1_Up,
  output logic                 o_P1_Dn,
  output logic                 o_P2_Up,
  output logic                 o_P2_Dn,
  output logic                 o_Start,
  output logic                 o_Pause,
  output logic                 o_Score_Clr,
  output logic [7:0]           o_Err_Count
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CLKS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

  state_e           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d, arg_q, arg_d, sum_q, sum_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       err_q, err_d;
  logic             p1_up_q, p1_up_d, p1_dn_q, p1_dn_d;
  logic             p2_up_q, p2_up_d, p2_dn_q, p2_dn_d;
  logic             start_q, start_d, pause_q, pause_d, clr_q, clr_d;
  logic             p1_reload_s, p2_reload_s, p1_expire_s, p2_expire_s;
  logic             move_cmd_s, cmd_known_s, pkt_ok_s;

  assign move_cmd_s  = (cmd_q == CMD_P1_MOVE) || (cmd_q == CMD_P2_MOVE);
  assign cmd_known_s = move_cmd_s || (cmd_q == CMD_START) || (cmd_q == CMD_PAUSE) ||
                       (cmd_q == CMD_SCORE_CLR);
  assign pkt_ok_s    = (pkt_sum(cmd_q, arg_q) == sum_q) && cmd_known_s &&
                       !(move_cmd_s && (arg_q > ARG_DOWN));

  // Expiry is applied first so a move executed in the same cycle overrides it.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    sum_d       = sum_q;
    tmo_d       = '0;
    err_d       = err_q;
    p1_up_d     = p1_up_q;
    p1_dn_d     = p1_dn_q;
    p2_up_d     = p2_up_q;
    p2_dn_d     = p2_dn_q;
    start_d     = 1'b0;
    pause_d     = 1'b0;
    clr_d       = 1'b0;
    p1_reload_s = 1'b0;
    p2_reload_s = 1'b0;

    if (p1_expire_s) begin
      p1_up_d = 1'b0;
      p1_dn_d = 1'b0;
    end else begin
      p1_up_d = p1_up_q;
    end
    if (p2_expire_s) begin
      p2_up_d = 1'b0;
      p2_dn_d = 1'b0;
    end else begin
      p2_up_d = p2_up_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx.i_RX_DV && (rx.i_RX_Byte == SYNC_BYTE)) begin
          state_d = ST_GET_CMD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GET_CMD, ST_GET_ARG, ST_GET_SUM: begin
        if (rx.i_RX_DV) begin
          if (state_q == ST_GET_CMD) begin
            cmd_d   = rx.i_RX_Byte;
            state_d = ST_GET_ARG;
          end else if (state_q == ST_GET_ARG) begin
            arg_d   = rx.i_RX_Byte;
            state_d = ST_GET_SUM;
          end else begin
            sum_d   = rx.i_RX_Byte;
            state_d = ST_EXEC;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
          err_d   = sat_inc(err_q);
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        if (!pkt_ok_s) begin
          err_d = sat_inc(err_q);
        end else begin
          case (cmd_q)
            CMD_P1_MOVE: begin
              p1_reload_s        = 1'b1;
              {p1_up_d, p1_dn_d} = move_levels(arg_q);
            end
            CMD_P2_MOVE: begin
              p2_reload_s        = 1'b1;
              {p2_up_d, p2_dn_d} = move_levels(arg_q);
            end
            CMD_START:     start_d = 1'b1;
            CMD_PAUSE:     pause_d = 1'b1;
            CMD_SCORE_CLR: clr_d   = 1'b1;
            default:       err_d   = err_q;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, packet fields, counters and all output flops.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= ST_IDLE;
      cmd_q   <= 8'h00;
      arg_q   <= 8'h00;
      sum_q   <= 8'h00;
      tmo_q   <= '0;
      err_q   <= 8'h00;
      p1_up_q <= 1'b0;
      p1_dn_q <= 1'b0;
      p2_up_q <= 1'b0;
      p2_dn_q <= 1'b0;
      start_q <= 1'b0;
      pause_q <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      arg_q   <= arg_d;
      sum_q   <= sum_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      p1_up_q <= p1_up_d;
      p1_dn_q <= p1_dn_d;
      p2_up_q <= p2_up_d;
      p2_dn_q <= p2_dn_d;
      start_q <= start_d;
      pause_q <= pause_d;
      clr_q   <= clr_d;
    end
  end

  paddle_hold_timer #(.HOLD_CLKS(HOLD_CLKS)) u_p1_hold (
    .clk_i    (i_Clock),
    .rst_ni   (i_Rst_L),
    .reload_i (p1_reload_s),
    .expire_o (p1_expire_s)
  );

  paddle_hold_timer #(.HOLD_CLKS(HOLD_CLKS)) u_p2_hold (
    .clk_i    (i_Clock),
    .rst_ni   (i_Rst_L),
    .reload_i (p2_reload_s),
    .expire_o (p2_expire_s)
  );

  assign o_P1_Up     = p1_up_q;
  assign o_P1_Dn     = p1_dn_q;
  assign o_P2_Up     = p2_up_q;
  assign o_P2_Dn     = p2_dn_q;
  assign o_Start     = start_q;
  assign o_Pause     = pause_q;
  assign o_Score_Clr = clr_q;
  assign o_Err_Count = err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: a packet model pushes expected outputs to a scoreboard
// that is popped one clock after each SUM strobe; hold/timeout/reset edges are checked directly.
module tb_uart_cmd_decoder;

  localparam int CPB  = 2;
  localparam int TMO  = 10 * CPB * 4;
  localparam int HOLD = 400;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       p1u, p1d, p2u, p2d, st, pa, sc;
  logic [7:0] errc;

  uart_cmd_decoder_if rx_if ();

  uart_cmd_decoder #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO), .HOLD_CLKS(HOLD)) dut (
    .i_Clock     (clk),
    .i_Rst_L     (rst_l),
    .rx          (rx_if.slave),
    .o_P1_Up     (p1u),
    .o_P1_Dn     (p1d),
    .o_P2_Up     (p2u),
    .o_P2_Dn     (p2d),
    .o_Start     (st),
    .o_Pause     (pa),
    .o_Score_Clr (sc),
    .o_Err_Count (errc)
  );

  always #5 clk = ~clk;

  wire [14:0] obs = {p1u, p1d, p2u, p2d, st, pa, sc, errc};

  int         n_assert = 0;
  int         n_fail   = 0;
  logic       m_p1u = 1'b0, m_p1d = 1'b0, m_p2u = 1'b0, m_p2d = 1'b0;
  logic       m_st = 1'b0, m_pa = 1'b0, m_sc = 1'b0;
  logic [7:0] m_err = 8'h00;
  logic [14:0] sb_q[$];

  function automatic logic [14:0] model_vec();
    return {m_p1u, m_p1d, m_p2u, m_p2d, m_st, m_pa, m_sc, m_err};
  endfunction

  task automatic check(input string tag, input logic [14:0] o, input logic [14:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_if.i_RX_DV   = 1'b1;
    rx_if.i_RX_Byte = b;
    @(posedge clk);
    #1;
    rx_if.i_RX_DV   = 1'b0;
    rx_if.i_RX_Byte = 8'h00;
  endtask

  task automatic model_pkt(input logic [7:0] c, input logic [7:0] a, input logic [7:0] s);
    logic [7:0] t;
    logic       ok;
    t  = c + a;
    ok = (t == s) && (c inside {8'h01, 8'h02, 8'h10, 8'h11, 8'h12}) &&
         !((c == 8'h01 || c == 8'h02) && a > 8'h02);
    if (!ok) begin
      m_err = (m_err == 8'hFF) ? 8'hFF : m_err + 8'd1;
    end else begin
      case (c)
        8'h01: {m_p1u, m_p1d} = (a == 8'h01) ? 2'b10 : (a == 8'h02) ? 2'b01 : 2'b00;
        8'h02: {m_p2u, m_p2d} = (a == 8'h01) ? 2'b10 : (a == 8'h02) ? 2'b01 : 2'b00;
        8'h10: m_st = 1'b1;
        8'h11: m_pa = 1'b1;
        default: m_sc = 1'b1;
      endcase
    end
    sb_q.push_back(model_vec());
    m_st = 1'b0;
    m_pa = 1'b0;
    m_sc = 1'b0;
  endtask

  // Ends at #1 after the edge two clocks past the SUM strobe.
  task automatic send_pkt(input string tag, input logic [7:0] c, input logic [7:0] a,
                          input logic [7:0] s);
    logic [14:0] e;
    model_pkt(c, a, s);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(a);
    send_byte(s);
    wait_edges(1);
    e = sb_q.pop_front();
    check(tag, obs, e);
    wait_edges(1);
    check({tag, "_next"}, obs, model_vec());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_if.i_RX_DV   = 1'b0;
    rx_if.i_RX_Byte = 8'h00;
    wait_edges(3);
    check("reset", obs, 15'h0000);
    @(negedge clk);
    rst_l = 1'b1;
    wait_edges(2);

    send_pkt("p1_up",   8'h01, 8'h01, 8'h02);
    send_pkt("p1_stop", 8'h01, 8'h00, 8'h01);
    send_pkt("start",   8'h10, 8'h00, 8'h10);
    send_pkt("pause",   8'h11, 8'h7F, 8'h90);
    send_pkt("sclr",    8'h12, 8'h00, 8'h12);
    send_pkt("bad_sum", 8'h02, 8'h02, 8'h05);
    send_pkt("bad_cmd", 8'h33, 8'h00, 8'h33);
    send_pkt("bad_arg", 8'h01, 8'h03, 8'h04);
    send_pkt("sync_as_cmd", 8'hA5, 8'h00, 8'hA5);

    // Abandoned frame: SYNC then CMD, then silence.
    send_byte(8'hA5);
    send_byte(8'h01);
    wait_edges(TMO - 3);
    check("tmo_before", obs, model_vec());
    wait_edges(5);
    m_err = m_err + 8'd1;
    check("tmo_after", obs, model_vec());
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    wait_edges(2);
    check("idle_junk", obs, model_vec());
    send_pkt("post_tmo", 8'h01, 8'h02, 8'h03);
    send_pkt("p1_stop2", 8'h01, 8'h00, 8'h01);

    // Hold expiry: levels set at S+1, cleared at S+HOLD; we are at S+2 here.
    send_pkt("p2_dn", 8'h02, 8'h02, 8'h04);
    wait_edges(HOLD - 3);
    check("hold_last", obs, model_vec());
    wait_edges(1);
    m_p2d = 1'b0;
    check("hold_expired", obs, model_vec());

    // Refresh whose EXEC cycle coincides with the expiry cycle.
    send_pkt("p2_dn2", 8'h02, 8'h02, 8'h04);
    wait_edges(HOLD - 7);
    send_pkt("collide", 8'h02, 8'h02, 8'h04);
    wait_edges(HOLD - 3);
    check("reload_last", obs, model_vec());
    wait_edges(1);
    m_p2d = 1'b0;
    check("reload_expired", obs, model_vec());

    for (int i = 0; i < 300; i++) begin
      send_pkt("sat", 8'h01, 8'h01, 8'h00);
    end
    check("sat_final", obs, {7'b0000000, 8'hFF});

    send_pkt("p2_up", 8'h02, 8'h01, 8'h03);
    send_byte(8'hA5);
    send_byte(8'h01);
    rst_l = 1'b0;
    #1;
    check("async_reset", obs, 15'h0000);
    {m_p1u, m_p1d, m_p2u, m_p2d} = 4'b0000;
    m_err = 8'h00;
    wait_edges(2);
    @(negedge clk);
    rst_l = 1'b1;
    wait_edges(1);
    send_pkt("post_reset", 8'h02, 8'h02, 8'h04);
    check("post_reset_err", {7'b0000000, errc}, 15'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
